// File: rtl/reg_wb_arbiter_if.sv
// Writeback requester handshake plus register-file write port, shared by arbiter and sources.
// slave = arbiter side, master = requester/register-file side.
interface reg_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    i_req_vld;
    logic [NREQ*AW-1:0] i_req_addr;
    logic [NREQ*DW-1:0] i_req_dat;
    logic [NREQ-1:0]    o_req_rdy;
    logic               o_wr_en;
    logic [AW-1:0]      o_wr_addr;
    logic [DW-1:0]      o_wr_dat;

    modport slave (
        input  i_req_vld, i_req_addr, i_req_dat,
        output o_req_rdy, o_wr_en, o_wr_addr, o_wr_dat
    );

    modport master (
        output i_req_vld, i_req_addr, i_req_dat,
        input  o_req_rdy, o_wr_en, o_wr_addr, o_wr_dat
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin (fixed priority when REG_WB_ARBITER_FIXED_PRIO_EN is defined) writeback arbiter with x1..x31 clear sequencer.
// Write port registered: one cycle from handshake; rdy is combinational and held low while a clear runs.
module reg_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_wb_arbiter_if.slave  bus,
    input  logic             i_clr_start,
    output logic             o_clr_busy,
    output logic             o_clr_done
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_dat_q, wr_dat_d;
`ifndef REG_WB_ARBITER_FIXED_PRIO_EN
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   cand;
`endif

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   win;
    logic            found;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_dat;

    // Grant depends only on valids, pointer and state, never on addr/data.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
`ifdef REG_WB_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.i_req_vld[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
`else
        cand = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && bus.i_req_vld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`endif
        if (found && state_q == ST_IDLE) begin
            gnt[win] = 1'b1;
        end
    end

    assign xfer = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_dat  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr = bus.i_req_addr[i*AW +: AW];
                sel_dat  = bus.i_req_dat[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
`ifndef REG_WB_ARBITER_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    wr_addr_d = sel_addr;
                    wr_dat_d  = sel_dat;
                    wr_en_d   = (sel_addr != '0);
`ifndef REG_WB_ARBITER_FIXED_PRIO_EN
                    ptr_d     = win;
`endif
                end
                // A grant taken in the same cycle still lands before the first clear write.
                if (i_clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CW'(1);
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = AW'(cnt_q);
                wr_dat_d  = '0;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(31)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
`ifndef REG_WB_ARBITER_FIXED_PRIO_EN
            ptr_q     <= PW'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
`ifndef REG_WB_ARBITER_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.o_req_rdy = gnt;
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_dat  = wr_dat_q;
    assign o_clr_busy    = (state_q != ST_IDLE);
    assign o_clr_done    = (state_q == ST_DONE);
endmodule
